// File: rtl/ocs_tx_slot_sched.sv
// ocs_tx_slot_sched
// Transmit scheduler between the per-destination egress queues and the
// optical circuit switch port. A slot window opens on i_slot_start. While it
// is open, at most one frame is granted at a time, and only to the queue whose
// destination matches the current circuit. A frame is granted only when it
// fits completely in the cycles left before the guard band.
//
// Ports
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_slot_start        : one-cycle pulse, a new circuit becomes valid
//   i_slot_id           : destination of the new circuit (sampled on i_slot_start)
//   i_q0_req/i_q0_len   : queue 0 head-frame request and length in cycles
//   i_q1_req/i_q1_len   : queue 1 head-frame request and length in cycles
//   i_frame_done        : one-cycle pulse, the granted frame has fully left
//   o_q0_grant          : queue 0 may transmit one frame (level)
//   o_q1_grant          : queue 1 may transmit one frame (level)
//   o_slot_active       : slot window open (o_remain != 0)
//   o_remain            : cycles left before the guard band
//   o_overrun           : one-cycle pulse, slot started while a grant was held
//   o_frame_cnt         : frames granted in the current slot, saturating
module ocs_tx_slot_sched #(
  parameter logic [15:0] P_SLOT_LEN = 16'h5CD0,
  parameter logic [15:0] P_GUARD    = 16'd64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_slot_start,
  input  logic        i_slot_id,
  input  logic        i_q0_req,
  input  logic [15:0] i_q0_len,
  input  logic        i_q1_req,
  input  logic [15:0] i_q1_len,
  input  logic        i_frame_done,
  output logic        o_q0_grant,
  output logic        o_q1_grant,
  output logic        o_slot_active,
  output logic [15:0] o_remain,
  output logic        o_overrun,
  output logic [7:0]  o_frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [15:0] LOAD_VAL = P_SLOT_LEN - P_GUARD;

  state_t      state_r, state_s;
  logic        dest_r, dest_s;
  logic [15:0] remain_r, remain_s;
  logic        grant0_r, grant0_s;
  logic        grant1_r, grant1_s;
  logic        overrun_r, overrun_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        sel_req_s;
  logic [15:0] sel_len_s;
  logic        fits_s;

  // Saturating frame counter increment.
  function automatic logic [7:0] cnt_inc(input logic [7:0] c);
    if (c == 8'hFF) begin
      cnt_inc = c;
    end else begin
      cnt_inc = c + 8'd1;
    end
  endfunction

  // Select the queue matching the current circuit and test whether its frame fits.
  always_comb begin
    sel_req_s = 1'b0;
    sel_len_s = 16'd0;
    if (dest_r == 1'b0) begin
      sel_req_s = i_q0_req;
      sel_len_s = i_q0_len;
    end else begin
      sel_req_s = i_q1_req;
      sel_len_s = i_q1_len;
    end
    // Equality is allowed: the frame then ends exactly at the guard boundary.
    fits_s = sel_req_s && (sel_len_s != 16'd0) && (sel_len_s <= remain_r);
  end

  // Next-state and next-output logic; a slot start overrides the per-state result.
  always_comb begin
    state_s   = state_r;
    dest_s    = dest_r;
    remain_s  = (remain_r != 16'd0) ? (remain_r - 16'd1) : 16'd0;
    grant0_s  = grant0_r;
    grant1_s  = grant1_r;
    overrun_s = 1'b0;
    cnt_s     = cnt_r;

    case (state_r)
      ST_IDLE: begin
        state_s  = ST_IDLE;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
      ST_WAIT: begin
        if (fits_s) begin
          state_s  = ST_SEND;
          grant0_s = ~dest_r;
          grant1_s = dest_r;
          cnt_s    = cnt_inc(cnt_r);
        end else if (remain_r == 16'd0) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SEND: begin
        // The grant is held until the frame finishes, even past the slot end.
        if (i_frame_done) begin
          grant0_s = 1'b0;
          grant1_s = 1'b0;
          state_s  = (remain_r != 16'd0) ? ST_WAIT : ST_IDLE;
        end else begin
          state_s = ST_SEND;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    endcase

    if (i_slot_start) begin
      dest_s    = i_slot_id;
      remain_s  = LOAD_VAL;
      cnt_s     = 8'd0;
      overrun_s = (state_r == ST_SEND);
      if ((state_r == ST_SEND) && !i_frame_done) begin
        // Frame in flight keeps its grant; the new circuit applies afterwards.
        state_s = ST_SEND;
      end else begin
        // No grant is issued in the cycle the circuit changes.
        state_s  = ST_WAIT;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      overrun_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dest_r    <= 1'b0;
      remain_r  <= 16'd0;
      grant0_r  <= 1'b0;
      grant1_r  <= 1'b0;
      overrun_r <= 1'b0;
      cnt_r     <= 8'd0;
    end else begin
      dest_r    <= dest_s;
      remain_r  <= remain_s;
      grant0_r  <= grant0_s;
      grant1_r  <= grant1_s;
      overrun_r <= overrun_s;
      cnt_r     <= cnt_s;
    end
  end

  assign o_q0_grant    = grant0_r;
  assign o_q1_grant    = grant1_r;
  assign o_slot_active = (remain_r != 16'd0);
  assign o_remain      = remain_r;
  assign o_overrun     = overrun_r;
  assign o_frame_cnt   = cnt_r;

endmodule

// File: tb/tb_ocs_tx_slot_sched.sv
// Directed bench for ocs_tx_slot_sched with a grant scoreboard.
module tb_ocs_tx_slot_sched;

  localparam int LOAD = 23696;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slot_start = 1'b0;
  logic        slot_id = 1'b0;
  logic        q0_req = 1'b0;
  logic [15:0] q0_len = 16'd0;
  logic        q1_req = 1'b0;
  logic [15:0] q1_len = 16'd0;
  logic        frame_done = 1'b0;
  logic        g0, g1, active, overrun;
  logic [15:0] remain;
  logic [7:0]  cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int q;
    int cnt;
  } exp_t;
  exp_t sb[$];

  ocs_tx_slot_sched dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_slot_start (slot_start),
    .i_slot_id    (slot_id),
    .i_q0_req     (q0_req),
    .i_q0_len     (q0_len),
    .i_q1_req     (q1_req),
    .i_q1_len     (q1_len),
    .i_frame_done (frame_done),
    .o_q0_grant   (g0),
    .o_q1_grant   (g1),
    .o_slot_active(active),
    .o_remain     (remain),
    .o_overrun    (overrun),
    .o_frame_cnt  (cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic slot(input logic id);
    slot_start = 1'b1;
    slot_id    = id;
    tick();
    slot_start = 1'b0;
  endtask

  task automatic push_exp(input int q, input int c);
    exp_t e;
    e.q   = q;
    e.cnt = c;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a grant, then compare it with the oldest expectation.
  task automatic wait_grant(input int max_cyc, input int exp_delay);
    int   n;
    exp_t e;
    n = 0;
    while (!(g0 || g1) && n < max_cyc) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("grant_q0", int'(g0), int'(e.q == 0));
      chk("grant_q1", int'(g1), int'(e.q == 1));
      chk("frame_cnt", int'(cnt), e.cnt);
      chk("grant_latency", n, exp_delay);
    end
  endtask

  task automatic finish_frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("grant_drop", int'(g0 | g1), 0);
  endtask

  initial begin
    int n;
    int seen;

    // Reset state
    tick();
    tick();
    chk("rst_g0", int'(g0), 0);
    chk("rst_g1", int'(g1), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_remain", int'(remain), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_cnt", int'(cnt), 0);
    rst = 1'b0;
    tick();

    // Basic grant on matching slot
    q0_req = 1'b1;
    q0_len = 16'd100;
    slot(1'b0);
    chk("load_remain", int'(remain), LOAD);
    chk("load_active", int'(active), 1);
    chk("no_early_grant", int'(g0), 0);
    push_exp(0, 1);
    wait_grant(5, 1);
    q0_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("grant_held", int'(g0), 1);
    chk("remain_dec", int'(remain), LOAD - 6);
    finish_frame();

    // Back-to-back frames of length 10
    q0_req = 1'b1;
    q0_len = 16'd10;
    for (int f = 0; f < 3; f++) begin
      push_exp(0, 2 + f);
      wait_grant(5, 1);
      for (int i = 0; i < 9; i++) tick();
      if (f == 2) q0_req = 1'b0;
      finish_frame();
    end

    // Slot start during SEND -> overrun, grant held, new dest afterwards
    q1_req = 1'b1;
    q1_len = 16'd50;
    slot(1'b1);
    chk("cnt_clear", int'(cnt), 0);
    push_exp(1, 1);
    wait_grant(5, 1);
    q0_req = 1'b1;
    q0_len = 16'd20;
    slot(1'b0);
    chk("ovr_pulse", int'(overrun), 1);
    chk("ovr_hold_g1", int'(g1), 1);
    chk("ovr_remain", int'(remain), LOAD);
    chk("ovr_cnt", int'(cnt), 0);
    tick();
    chk("ovr_once", int'(overrun), 0);
    chk("ovr_hold2_g1", int'(g1), 1);
    chk("ovr_no_g0", int'(g0), 0);
    q1_req = 1'b0;
    finish_frame();
    push_exp(0, 1);
    wait_grant(5, 1);
    finish_frame();
    push_exp(0, 2);
    wait_grant(5, 1);

    // Slot start and frame done together in SEND
    slot_start = 1'b1;
    slot_id    = 1'b0;
    frame_done = 1'b1;
    tick();
    slot_start = 1'b0;
    frame_done = 1'b0;
    chk("both_ovr", int'(overrun), 1);
    chk("both_drop", int'(g0), 0);
    chk("both_remain", int'(remain), LOAD);
    chk("both_cnt", int'(cnt), 0);
    push_exp(0, 1);
    wait_grant(5, 1);
    q0_req = 1'b0;
    finish_frame();

    // Length one above remaining: not granted; granted in next slot
    slot(1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("fit_remain", int'(remain), LOAD - 10);
    q0_req = 1'b1;
    q0_len = 16'(LOAD - 10 + 1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | int'(g0 | g1);
    end
    chk("len_plus1_no_grant", seen, 0);
    slot(1'b0);
    push_exp(0, 1);
    wait_grant(5, 1);
    q0_req = 1'b0;
    finish_frame();

    // Length equal to remaining: granted
    slot(1'b0);
    for (int i = 0; i < 10; i++) tick();
    q0_req = 1'b1;
    q0_len = 16'(LOAD - 10);
    push_exp(0, 1);
    wait_grant(3, 1);
    q0_req = 1'b0;
    finish_frame();

    // Zero length never granted
    q0_req = 1'b1;
    q0_len = 16'd0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | int'(g0 | g1);
    end
    chk("zero_len", seen, 0);
    q0_req = 1'b0;

    // Asynchronous reset while q1 is granted
    q1_req = 1'b1;
    q1_len = 16'd30;
    slot(1'b1);
    push_exp(1, 1);
    wait_grant(5, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_g1", int'(g1), 0);
    chk("arst_active", int'(active), 0);
    chk("arst_remain", int'(remain), 0);
    chk("arst_cnt", int'(cnt), 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | int'(g0 | g1 | active);
    end
    chk("post_rst_idle", seen, 0);
    q1_req = 1'b0;

    // Non-matching slot: no grant for the whole slot, window closes
    q0_req = 1'b1;
    q0_len = 16'd100;
    slot(1'b1);
    n    = 0;
    seen = 0;
    while (active && n < LOAD + 100) begin
      tick();
      n++;
      seen = seen | int'(g0 | g1);
    end
    chk("nomatch_no_grant", seen, 0);
    chk("slot_length", n, LOAD);
    chk("end_remain", int'(remain), 0);
    q1_req = 1'b1;
    q1_len = 16'd10;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | int'(g0 | g1);
    end
    chk("idle_no_grant", seen, 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ocs_tx_slot_sched.md
# ocs_tx_slot_sched

Transmit scheduler between the per-destination egress queues and the optical circuit switch port. It consumes the slot timing produced by the OCS slot controller (`i_slot_start` pulse, `i_slot_id`) and grants at most one frame at a time, always to the queue whose destination matches the current circuit. A frame is granted only if it fits completely in the time remaining before the guard band, so no frame is ever cut by a switch reconfiguration. Frames that do not fit wait for the next matching slot.

## Interface
- `P_SLOT_LEN`, 16'h5CD0: usable slot length in cycles. Must equal the slot controller's slot length.
- `P_GUARD`, 16'd64: guard cycles reserved at the end of each slot. Constraint: `P_GUARD < P_SLOT_LEN`.
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_slot_start`, in, 1: one-cycle pulse; a new circuit becomes valid.
- `i_slot_id`, in, 1: circuit/destination index; sampled on `i_slot_start`.
- `i_q0_req`, in, 1: queue 0 (destination 0) holds a frame ready to send.
- `i_q0_len`, in, 16: queue 0 head-frame length in cycles; valid while `i_q0_req` is high.
- `i_q1_req`, in, 1: queue 1 (destination 1) holds a frame ready to send.
- `i_q1_len`, in, 16: queue 1 head-frame length in cycles; valid while `i_q1_req` is high.
- `i_frame_done`, in, 1: one-cycle pulse; the granted frame's last beat has left.
- `o_q0_grant`, out, 1: level; queue 0 may transmit one frame.
- `o_q1_grant`, out, 1: level; queue 1 may transmit one frame.
- `o_slot_active`, out, 1: a slot window is open (`r_remain > 0`).
- `o_remain`, out, 16: cycles left before the guard band.
- `o_overrun`, out, 1: one-cycle pulse; `i_slot_start` arrived while a frame was still granted.
- `o_frame_cnt`, out, 8: frames granted in the current slot; saturates at 255.

## Operation
- States: IDLE (no slot open), WAIT (slot open, no grant), SEND (one grant held).
- On `i_slot_start`, in any state:
  - latch `r_dest <= i_slot_id`;
  - load `r_remain <= P_SLOT_LEN - P_GUARD`;
  - clear `o_frame_cnt`;
  - IDLE and WAIT go to WAIT; SEND stays in SEND and pulses `o_overrun`.
- `r_remain` decrements by 1 each cycle while it is above 0 and no `i_slot_start` is present. It never wraps below 0.
- `o_slot_active` equals `(r_remain != 0)`.
- WAIT:
  - Let `sel_req` and `sel_len` be the request and length of queue `r_dest`.
  - If `sel_req && sel_len != 0 && sel_len <= r_remain`: assert grant `r_dest`, increment `o_frame_cnt`, go to SEND.
  - If `r_remain == 0`: go to IDLE.
  - The other queue is never granted.
- SEND:
  - The grant is held until `i_frame_done`, regardless of `i_qX_req` or the slot ending.
  - On `i_frame_done`: drop the grant; go to WAIT if `r_remain != 0`, else go to IDLE.
- In IDLE and WAIT, `i_frame_done` is ignored.
- A request with a zero length is never granted.
- Length comparison is 16-bit unsigned. Equality is allowed (the frame ends exactly at the guard boundary).
- `o_q0_grant` and `o_q1_grant` are never high together.

## Timing
- Reset values:
  - state: IDLE;
  - `r_dest`: 0;
  - `o_remain`: 0;
  - all grants, `o_slot_active`, `o_overrun`, `o_frame_cnt`: 0.
- All outputs are registered.
- `i_slot_start` at cycle N:
  - at N+1: `o_remain = P_SLOT_LEN - P_GUARD`, `o_slot_active = 1`;
  - the earliest grant is at N+2, evaluated against `o_remain` at N+1.
- `i_frame_done` at cycle M: grant low at M+1. The earliest next grant is at M+2.
- `o_overrun` is high for exactly the cycle after the offending `i_slot_start`.
- If `i_slot_start` and `i_frame_done` occur in the same cycle in SEND: the slot reload takes effect, the grant drops, the state goes to WAIT, and `o_overrun` still pulses.
- Reset asserted mid-frame: all outputs clear immediately (asynchronous reset); any frame already started must be discarded by the queue logic.

## Test plan
- Slot_start with id=0, `q0_req=1`, `len=100` -> `o_q0_grant` rises 2 cycles later; `o_remain` = 23696 at N+1; `o_frame_cnt` = 1.
- Slot id=1 with only `q0_req=1` -> no grant for the whole slot; `o_slot_active` falls after 23696 cycles; state returns to IDLE.
- `len = o_remain` exactly -> granted; `len = o_remain + 1` -> not granted; the same frame is granted in the next id=0 slot.
- Back-to-back frames of `len=10`, `i_frame_done` 10 cycles after each grant -> grants are separated by 1 low cycle; `o_frame_cnt` counts each frame.
- `i_slot_start` during SEND -> `o_overrun` pulses once, the grant holds until `i_frame_done`, and the new `r_dest` is applied afterwards.
- `i_rst` asserted while `o_q1_grant` = 1 -> all outputs are 0 immediately; after release, nothing is granted until the next `i_slot_start`.
